// File: rtl/inst_decode.sv
// inst_decode: MIPS ID stage. Holds the IF/ID pipeline register, decodes the
// latched instruction into fields and control, and reads a 32x32 register
// file written by WB. Optional macro WB_BYPASS_EN makes same-cycle WB writes
// visible on rs_data/rt_data (write-through); without it, new data appears
// the cycle after the write.
module inst_decode #(
    parameter int              DATA_W   = 32,
    parameter int              REG_NUM  = 32,
    parameter logic [31:0]     NOP_INST = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [31:0]                inst_code,
    input  logic [DATA_W-1:0]          PC,
    input  logic                       stall,
    input  logic                       flush,
    input  logic                       wb_we,
    input  logic [$clog2(REG_NUM)-1:0] wb_addr,
    input  logic [DATA_W-1:0]          wb_data,
    output logic                       id_valid,
    output logic [DATA_W-1:0]          id_pc,
    output logic [31:0]                id_inst,
    output logic [4:0]                 rs,
    output logic [4:0]                 rt,
    output logic [4:0]                 rd,
    output logic [4:0]                 shamt,
    output logic [DATA_W-1:0]          imm_ext,
    output logic [DATA_W-1:0]          jmp_target,
    output logic [DATA_W-1:0]          rs_data,
    output logic [DATA_W-1:0]          rt_data,
    output logic                       reg_write,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic                       mem_to_reg,
    output logic                       alu_src,
    output logic                       reg_dst,
    output logic                       branch,
    output logic                       jump,
    output logic [3:0]                 alu_op,
    output logic                       illegal
);

    localparam int IDX_W = $clog2(REG_NUM);

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLT = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // IF/ID pipeline register
    logic              r_valid;
    logic [DATA_W-1:0] r_pc;
    logic [31:0]       r_inst;

    // Register file storage
    logic [DATA_W-1:0] r_regs [REG_NUM];

    // Raw (ungated) decode results
    logic    w_reg_write;
    logic    w_mem_read;
    logic    w_mem_write;
    logic    w_mem_to_reg;
    logic    w_alu_src;
    logic    w_reg_dst;
    logic    w_branch;
    logic    w_jump;
    logic    w_zero_ext;
    logic    w_unsupported;
    alu_op_e w_alu_op;

    logic [5:0]        w_opcode;
    logic [5:0]        w_funct;
    logic [15:0]       w_imm16;
    logic [DATA_W-1:0] w_pc_plus4;
    logic [DATA_W-1:0] w_rs_stored;
    logic [DATA_W-1:0] w_rt_stored;
    logic              w_live;

    // IF/ID update: flush squashes (pc kept), stall holds, otherwise load
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (!reset) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_inst  <= NOP_INST;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_inst  <= NOP_INST;
        end else if (!stall) begin
            r_valid <= 1'b1;
            r_pc    <= PC;
            r_inst  <= inst_code;
        end
    end

    // Register file write port; $0 is never written
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: this memory is reset because the block must present all-zero registers after reset.
        if (!reset) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_we && (wb_addr != '0)) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    assign w_opcode = r_inst[31:26];
    assign w_funct  = r_inst[5:0];
    assign w_imm16  = r_inst[15:0];

    // Opcode/funct decode into raw control signals
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        w_reg_write   = 1'b0;
        w_mem_read    = 1'b0;
        w_mem_write   = 1'b0;
        w_mem_to_reg  = 1'b0;
        w_alu_src     = 1'b0;
        w_reg_dst     = 1'b0;
        w_branch      = 1'b0;
        w_jump        = 1'b0;
        w_zero_ext    = 1'b0;
        w_unsupported = 1'b0;
        w_alu_op      = ALU_ADD;
        unique case (w_opcode)
            OP_RTYPE: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
                case (w_funct)
                    FN_ADD:  w_alu_op = ALU_ADD;
                    FN_SUB:  w_alu_op = ALU_SUB;
                    FN_AND:  w_alu_op = ALU_AND;
                    FN_OR:   w_alu_op = ALU_OR;
                    FN_SLT:  w_alu_op = ALU_SLT;
                    FN_SLL:  w_alu_op = ALU_SLL;
                    FN_SRL:  w_alu_op = ALU_SRL;
                    default: w_unsupported = 1'b1;
                endcase
            end
            OP_ADDI: begin
                w_reg_write = 1'b1;
                w_alu_src   = 1'b1;
            end
            OP_ANDI: begin
                w_reg_write = 1'b1;
                w_alu_src   = 1'b1;
                w_zero_ext  = 1'b1;
                w_alu_op    = ALU_AND;
            end
            OP_ORI: begin
                w_reg_write = 1'b1;
                w_alu_src   = 1'b1;
                w_zero_ext  = 1'b1;
                w_alu_op    = ALU_OR;
            end
            OP_LW: begin
                w_reg_write  = 1'b1;
                w_mem_read   = 1'b1;
                w_mem_to_reg = 1'b1;
                w_alu_src    = 1'b1;
            end
            OP_SW: begin
                w_mem_write = 1'b1;
                w_alu_src   = 1'b1;
            end
            OP_BEQ: begin
                w_branch = 1'b1;
                w_alu_op = ALU_SUB;
            end
            OP_J: begin
                w_jump = 1'b1;
            end
            default: w_unsupported = 1'b1;
        endcase
    end

    // State-changing controls only fire for a live, legal instruction
    assign w_live = r_valid && !w_unsupported;

    assign reg_write  = w_live && w_reg_write;
    assign mem_read   = w_live && w_mem_read;
    assign mem_write  = w_live && w_mem_write;
    assign branch     = w_live && w_branch;
    assign jump       = w_live && w_jump;
    assign mem_to_reg = r_valid && w_mem_to_reg;
    assign alu_src    = r_valid && w_alu_src;
    assign reg_dst    = r_valid && w_reg_dst;
    assign alu_op     = r_valid ? w_alu_op : ALU_ADD;
    assign illegal    = r_valid && w_unsupported;

    // Fields and immediates straight from the latched word
    assign id_valid = r_valid;
    assign id_pc    = r_pc;
    assign id_inst  = r_inst;
    assign rs       = r_inst[25:21];
    assign rt       = r_inst[20:16];
    assign rd       = r_inst[15:11];
    assign shamt    = r_inst[10:6];
    assign imm_ext  = w_zero_ext ? {{(DATA_W-16){1'b0}}, w_imm16}
                                 : {{(DATA_W-16){w_imm16[15]}}, w_imm16};

    assign w_pc_plus4 = r_pc + DATA_W'(4);
    assign jmp_target = (w_pc_plus4 & {4'hF, {(DATA_W-4){1'b0}}})
                      | {{(DATA_W-28){1'b0}}, r_inst[25:0], 2'b00};

    // Asynchronous reads; $0 always reads zero
    assign w_rs_stored = (rs == 5'd0) ? '0 : r_regs[rs[IDX_W-1:0]];
    assign w_rt_stored = (rt == 5'd0) ? '0 : r_regs[rt[IDX_W-1:0]];

`ifdef WB_BYPASS_EN
    assign rs_data = (wb_we && (wb_addr != '0) && (wb_addr == rs[IDX_W-1:0])) ? wb_data : w_rs_stored;
    assign rt_data = (wb_we && (wb_addr != '0) && (wb_addr == rt[IDX_W-1:0])) ? wb_data : w_rt_stored;
`else
    assign rs_data = w_rs_stored;
    assign rt_data = w_rt_stored;
`endif

endmodule

// File: tb/tb_inst_decode.sv
// Directed testbench for inst_decode with hand-computed expected values.
module tb_inst_decode;

    logic        clk;
    logic        reset;
    logic [31:0] inst_code;
    logic [31:0] PC;
    logic        stall;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] imm_ext, jmp_target, rs_data, rt_data;
    logic        reg_write, mem_read, mem_write, mem_to_reg;
    logic        alu_src, reg_dst, branch, jump, illegal;
    logic [3:0]  alu_op;

    int errors = 0;
    int checks = 0;

    inst_decode dut (
        .clk        (clk),
        .reset      (reset),
        .inst_code  (inst_code),
        .PC         (PC),
        .stall      (stall),
        .flush      (flush),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .id_valid   (id_valid),
        .id_pc      (id_pc),
        .id_inst    (id_inst),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .shamt      (shamt),
        .imm_ext    (imm_ext),
        .jmp_target (jmp_target),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .reg_write  (reg_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_to_reg (mem_to_reg),
        .alu_src    (alu_src),
        .reg_dst    (reg_dst),
        .branch     (branch),
        .jump       (jump),
        .alu_op     (alu_op),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] inst, input logic [31:0] pc);
        inst_code = inst;
        PC        = pc;
        tick();
    endtask

    initial begin
        reset = 1'b0; inst_code = 32'h0; PC = 32'h0; stall = 1'b0; flush = 1'b0;
        wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
        #1;
        check("rst_valid", 32'(id_valid), 32'h0);
        check("rst_inst",  id_inst, 32'h0);
        check("rst_pc",    id_pc, 32'h0);
        check("rst_rsdata", rs_data, 32'h0);
        check("rst_aluop", 32'(alu_op), 32'h0);
        check("rst_regdst", 32'(reg_dst), 32'h0);
        check("rst_jtgt",  jmp_target, 32'h0);
        #11 reset = 1'b1;   // released between edges

        // addi $8,$0,5
        load(32'h2008_0005, 32'h4);
        check("addi_valid", 32'(id_valid), 32'h1);
        check("addi_rt",    32'(rt), 32'd8);
        check("addi_imm",   imm_ext, 32'h5);
        check("addi_alusrc", 32'(alu_src), 32'h1);
        check("addi_regwr", 32'(reg_write), 32'h1);
        check("addi_regdst", 32'(reg_dst), 32'h0);
        check("addi_aluop", 32'(alu_op), 32'd0);
        check("addi_pc",    id_pc, 32'h4);
        check("addi_ill",   32'(illegal), 32'h0);

        // ori zero-extends, addi sign-extends
        load(32'h3408_FFFF, 32'h8);
        check("ori_imm",   imm_ext, 32'h0000_FFFF);
        check("ori_aluop", 32'(alu_op), 32'd3);
        load(32'h2008_FFFF, 32'hC);
        check("addi_neg_imm", imm_ext, 32'hFFFF_FFFF);

        // add $10,$9,$0 then hold it while WB writes $9 and $0
        load(32'h0120_5020, 32'h10);
        check("add_rs",     32'(rs), 32'd9);
        check("add_rd",     32'(rd), 32'd10);
        check("add_regdst", 32'(reg_dst), 32'h1);
        check("add_rs_old", rs_data, 32'h0);
        stall = 1'b1;
        wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'hDEAD_BEEF;
        #1;
`ifdef WB_BYPASS_EN
        check("wb_same_cycle", rs_data, 32'hDEAD_BEEF);
`else
        check("wb_same_cycle", rs_data, 32'h0);
`endif
        tick();
        check("wb_after_edge", rs_data, 32'hDEAD_BEEF);
        wb_addr = 5'd0; wb_data = 32'h0000_1234;
        #1;
        check("wb_r0_same", rt_data, 32'h0);
        tick();
        wb_we = 1'b0;
        check("wb_r0_after", rt_data, 32'h0);
        check("stall_hold_add", id_inst, 32'h0120_5020);
        stall = 1'b0;

        // sub $11,$9,$10 then stall 2 edges, then flush+stall
        load(32'h012A_5822, 32'h20);
        check("sub_aluop", 32'(alu_op), 32'd1);
        check("sub_rsdata", rs_data, 32'hDEAD_BEEF);
        check("sub_rtdata", rt_data, 32'h0);
        stall = 1'b1;
        load(32'h2008_FFFF, 32'h24);
        check("stall1_inst", id_inst, 32'h012A_5822);
        tick();
        check("stall2_inst", id_inst, 32'h012A_5822);
        check("stall2_pc",   id_pc, 32'h20);
        flush = 1'b1;
        tick();
        check("flush_valid", 32'(id_valid), 32'h0);
        check("flush_inst",  id_inst, 32'h0);
        check("flush_regwr", 32'(reg_write), 32'h0);
        check("flush_pc",    id_pc, 32'h20);
        flush = 1'b0; stall = 1'b0;

        // illegal opcode and illegal funct
        load(32'hFC00_0000, 32'h30);
        check("ill_op",      32'(illegal), 32'h1);
        check("ill_regwr",   32'(reg_write), 32'h0);
        check("ill_memwr",   32'(mem_write), 32'h0);
        check("ill_memrd",   32'(mem_read), 32'h0);
        check("ill_branch",  32'(branch), 32'h0);
        check("ill_jump",    32'(jump), 32'h0);
        load(32'h0000_003F, 32'h34);
        check("ill_funct",   32'(illegal), 32'h1);
        check("ill_fn_regwr", 32'(reg_write), 32'h0);
        load(32'h0000_0000, 32'h38);
        check("nop_ill",     32'(illegal), 32'h0);

        // j 0x10 at PC 0x40000000
        load(32'h0800_0010, 32'h4000_0000);
        check("j_jump",   32'(jump), 32'h1);
        check("j_target", jmp_target, 32'h4000_0040);
        check("j_regwr",  32'(reg_write), 32'h0);

        // lw / sw / beq / sll
        load(32'h8D2B_0004, 32'h40);
        check("lw_memrd", 32'(mem_read), 32'h1);
        check("lw_m2r",   32'(mem_to_reg), 32'h1);
        check("lw_regwr", 32'(reg_write), 32'h1);
        check("lw_rsdata", rs_data, 32'hDEAD_BEEF);
        load(32'hAD2B_0004, 32'h44);
        check("sw_memwr", 32'(mem_write), 32'h1);
        check("sw_regwr", 32'(reg_write), 32'h0);
        load(32'h1109_FFFE, 32'h48);
        check("beq_branch", 32'(branch), 32'h1);
        check("beq_aluop",  32'(alu_op), 32'd1);
        check("beq_imm",    imm_ext, 32'hFFFF_FFFE);
        load(32'h0008_4080, 32'h4C);
        check("sll_shamt", 32'(shamt), 32'd2);
        check("sll_aluop", 32'(alu_op), 32'd5);

        // Mid-run async reset clears everything without a clock edge
        load(32'h0120_5020, 32'h50);
        check("pre_rst_rsdata", rs_data, 32'hDEAD_BEEF);
        #2 reset = 1'b0;
        #1;
        check("midrst_valid",  32'(id_valid), 32'h0);
        check("midrst_inst",   id_inst, 32'h0);
        check("midrst_rsdata", rs_data, 32'h0);
        check("midrst_regwr",  32'(reg_write), 32'h0);
        reset = 1'b1;
        load(32'h0120_5020, 32'h54);
        check("post_rst_valid",  32'(id_valid), 32'h1);
        check("post_rst_rsdata", rs_data, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
